audio_sample_fifo: RTL and testbench

- Stereo sample buffer between sample_processor and the I2S shift_register.
- Decouples sample production on audio_clk_out from frame-paced consumption by the serializer.
- Accepts L/R sample pairs with a valid/ready handshake and answers frame-boundary read requests from shift_register.
- Mutes on underrun, and MSB-justifies and masks samples to the active sample size.

---
 rtl/audio_pkg.sv | 31 +++
 rtl/audio_fifo_mem.sv | 27 ++
 rtl/audio_sample_fifo.sv | 177 +++++++++++++++++
 tb/tb_audio_sample_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path: sample-size codes,
// the code-to-width mapping and the default channel sample width.
package audio_pkg;

  // Default width of one channel sample in bits.
  localparam int AUDIO_DATA_W = 32;

  // Sample-size codes as delivered by the configuration registers.
  // Codes 2, 6 and 7 are unassigned and fall back to 16-bit handling.
  typedef enum logic [2:0] {
    S_8BIT  = 3'd0,
    S_12BIT = 3'd1,
    S_16BIT = 3'd3,
    S_24BIT = 3'd4,
    S_32BIT = 3'd5
  } sample_size_e;

  // Active sample width in bits for a size code; unknown codes map to 16.
  function automatic int unsigned sample_width(input logic [2:0] code);
    int unsigned w;
    case (sample_size_e'(code))
      S_8BIT:  w = 8;
      S_12BIT: w = 12;
      S_24BIT: w = 24;
      S_32BIT: w = 32;
      default: w = 16;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/audio_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
// Holds one stereo pair per entry for audio_sample_fifo.
module audio_fifo_mem #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_reg [2**ADDR_W];

  // Store the incoming pair at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Read is combinational so the head entry is available in the request cycle.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO between sample_processor and the I2S shift_register.
// Writes use a valid/ready handshake; reads are frame-start pulses that
// return MSB-justified, size-masked samples one cycle later, or a mute
// pair (with a sticky underrun flag) when the FIFO is empty.
// Optional build macro AUDIO_FIFO_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun_count output.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DATA_W          = AUDIO_DATA_W,
  parameter int DEPTH_LOG2      = 3,
  parameter int ALMOST_FULL_LVL = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            sample_size,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_left,
  input  logic [DATA_W-1:0]     wr_right,
  output logic                  wr_ready,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_left,
  output logic [DATA_W-1:0]     rd_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  underrun
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LVL   = (DEPTH_LOG2 + 1)'(ALMOST_FULL_LVL);

  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  almost_full_reg;
  logic                  rd_valid_reg;
  logic [DATA_W-1:0]     rd_left_reg;
  logic [DATA_W-1:0]     rd_right_reg;
  logic                  underrun_reg;

  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_hit;
  logic                  rd_mute;

  logic [2*DATA_W-1:0]       mem_wdata;
  logic [2*DATA_W-1:0]       mem_rdata;
  // Channel 1 is left, channel 0 is right, matching the packed memory word.
  logic [1:0][DATA_W-1:0]    raw_chan;
  logic [1:0][DATA_W-1:0]    just_chan;

  // Place the low W bits of a sample at the top of the word; the shift
  // drops everything above W and zero-fills below.
  function automatic logic [DATA_W-1:0] msb_justify(input logic [DATA_W-1:0] s,
                                                    input logic [2:0]        code);
    int unsigned w;
    w = sample_width(code);
    if (w > DATA_W) begin
      w = DATA_W;
    end
    return s << (DATA_W - w);
  endfunction

  // Status comes from the registered level only, so a read in the same
  // cycle never frees room for a write that the producer already saw refused.
  assign full     = (level_reg == FULL_LVL);
  assign empty    = (level_reg == '0);
  assign wr_ready = !full;
  assign wr_en    = wr_valid && !full;
  assign rd_hit   = rd_req && !empty;
  assign rd_mute  = rd_req && empty;

  assign mem_wdata = {wr_left, wr_right};

  audio_fifo_mem #(
    .WIDTH  (2 * DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (mem_wdata),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  assign raw_chan = mem_rdata;

  // Both channels share the same justification using the read-time size code.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign just_chan[gi] = msb_justify(raw_chan[gi], sample_size);
    end
  endgenerate

  // Level moves by one on a lone write or lone read; both or neither holds it.
  always_comb begin
    level_next = level_reg;
    if (wr_en && !rd_hit) begin
      level_next = level_reg + 1'b1;
    end else if (rd_hit && !wr_en) begin
      level_next = level_reg - 1'b1;
    end
  end

  // Pointer, level and almost_full registers; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      almost_full_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_hit) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg       <= level_next;
      almost_full_reg <= (level_next >= AF_LVL);
    end
  end

  // Read response: every rd_req yields a one-cycle rd_valid with either the
  // head pair or silence; the output samples hold between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_left_reg  <= '0;
      rd_right_reg <= '0;
      underrun_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      if (rd_hit) begin
        rd_left_reg  <= just_chan[1];
        rd_right_reg <= just_chan[0];
      end else if (rd_mute) begin
        rd_left_reg  <= '0;
        rd_right_reg <= '0;
        underrun_reg <= 1'b1;
      end
    end
  end

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_reg;

  // Count empty reads, sticking at the maximum rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count_reg <= '0;
    end else if (rd_mute && (underrun_count_reg != 16'hFFFF)) begin
      underrun_count_reg <= underrun_count_reg + 16'd1;
    end
  end

  assign underrun_count = underrun_count_reg;
`endif

  assign level       = level_reg;
  assign almost_full = almost_full_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_left     = rd_left_reg;
  assign rd_right    = rd_right_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed self-checking bench for audio_sample_fifo (default parameters).
module tb_audio_sample_fifo;

  logic        clk;
  logic        rst;
  logic [2:0]  sample_size;
  logic        wr_valid;
  logic [31:0] wr_left;
  logic [31:0] wr_right;
  logic        wr_ready;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_left;
  logic [31:0] rd_right;
  logic [3:0]  level;
  logic        almost_full;
  logic        underrun;
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int n_checks;
  int n_pass;

  audio_sample_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .sample_size (sample_size),
    .wr_valid    (wr_valid),
    .wr_left     (wr_left),
    .wr_right    (wr_right),
    .wr_ready    (wr_ready),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_left     (rd_left),
    .rd_right    (rd_right),
    .level       (level),
    .almost_full (almost_full),
    .underrun    (underrun)
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    wr_left  = l;
    wr_right = r;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] l, input logic [31:0] r);
    pop();
    $display("read %s: left=0x%08h right=0x%08h level=%0d", tag, rd_left, rd_right, level);
    check({tag, "_valid"}, 64'(rd_valid), 64'(1'b1));
    check({tag, "_left"},  64'(rd_left),  64'(l));
    check({tag, "_right"}, 64'(rd_right), 64'(r));
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    sample_size = 3'd3;
    wr_valid    = 1'b0;
    wr_left     = '0;
    wr_right    = '0;
    rd_req      = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    rst = 1'b0;
    check("rst_wr_ready", 64'(wr_ready),    64'(1'b1));
    check("rst_level",    64'(level),       64'(4'd0));
    check("rst_left",     64'(rd_left),     64'(32'd0));
    check("rst_right",    64'(rd_right),    64'(32'd0));
    check("rst_underrun", 64'(underrun),    64'(1'b0));
    check("rst_af",       64'(almost_full), 64'(1'b0));
    check("rst_valid",    64'(rd_valid),    64'(1'b0));
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    check("rst_ucnt",     64'(underrun_count), 64'(16'd0));
`endif

    // Basic ordering at 16-bit size.
    sample_size = 3'd3;
    push(32'h0000_1234, 32'h0000_ABCD);
    check("basic_lvl1", 64'(level), 64'(4'd1));
    push(32'h0000_0001, 32'h0000_0002);
    check("basic_lvl2", 64'(level), 64'(4'd2));
    check("basic_no_early_valid", 64'(rd_valid), 64'(1'b0));
    pop_expect("basic0", 32'h1234_0000, 32'hABCD_0000);
    check("basic_lvl_after1", 64'(level), 64'(4'd1));
    tick();
    check("basic_valid_pulse", 64'(rd_valid), 64'(1'b0));
    check("basic_hold_left",   64'(rd_left),  64'(32'h1234_0000));
    pop_expect("basic1", 32'h0001_0000, 32'h0002_0000);
    check("basic_lvl_after2", 64'(level), 64'(4'd0));

    // Fill to full at 32-bit size (identity transform).
    sample_size = 3'd5;
    for (int i = 0; i < 8; i++) begin
      push(32'(i), 32'(i + 256));
      $display("write fill %0d: level=%0d almost_full=%0b", i, level, almost_full);
      check("fill_level", 64'(level), 64'(i + 1));
      check("fill_af",    64'(almost_full), 64'((i + 1) >= 6));
    end
    check("full_wr_ready", 64'(wr_ready), 64'(1'b0));

    // Ninth write is held off while full.
    wr_left  = 32'd99;
    wr_right = 32'd99;
    wr_valid = 1'b1;
    tick();
    check("full_refused_level", 64'(level), 64'(4'd8));

    // Write and read together while full: read served, write refused.
    rd_req = 1'b1;
    tick();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    $display("simul full: left=0x%08h level=%0d", rd_left, level);
    check("simfull_valid", 64'(rd_valid), 64'(1'b1));
    check("simfull_left",  64'(rd_left),  64'(32'd0));
    check("simfull_right", 64'(rd_right), 64'(32'd256));
    check("simfull_level", 64'(level),    64'(4'd7));
    check("simfull_af",    64'(almost_full), 64'(1'b1));
    check("simfull_ready", 64'(wr_ready), 64'(1'b1));

    pop_expect("wrap1", 32'd1, 32'd257);
    pop_expect("wrap2", 32'd2, 32'd258);
    check("wrap_level5", 64'(level), 64'(4'd5));
    check("wrap_af_low", 64'(almost_full), 64'(1'b0));

    for (int i = 8; i <= 10; i++) begin
      push(32'(i), 32'(i + 256));
    end
    check("wrap_level8", 64'(level), 64'(4'd8));
    for (int i = 3; i <= 10; i++) begin
      pop_expect("wrap_rd", 32'(i), 32'(i + 256));
    end
    check("wrap_empty", 64'(level), 64'(4'd0));
    check("wrap_no_underrun", 64'(underrun), 64'(1'b0));

    // Underrun: read while empty mutes the output and sets the sticky flag.
    pop_expect("underrun", 32'd0, 32'd0);
    check("underrun_flag",  64'(underrun), 64'(1'b1));
    check("underrun_level", 64'(level),    64'(4'd0));
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    check("ucnt_1", 64'(underrun_count), 64'(16'd1));
`endif

    // Write and read together while empty: mute output, write stored.
    wr_left  = 32'h0000_0055;
    wr_right = 32'h0000_0066;
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    tick();
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    $display("simul empty: left=0x%08h level=%0d", rd_left, level);
    check("simempty_valid", 64'(rd_valid), 64'(1'b1));
    check("simempty_left",  64'(rd_left),  64'(32'd0));
    check("simempty_level", 64'(level),    64'(4'd1));
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    check("ucnt_2", 64'(underrun_count), 64'(16'd2));
`endif
    pop_expect("after_simempty", 32'h0000_0055, 32'h0000_0066);
    check("underrun_sticky", 64'(underrun), 64'(1'b1));

    // Size masking and justification, with the size applied at read time.
    sample_size = 3'd0;
    push(32'hFFFF_FFA5, 32'h1234_5678);
    pop_expect("size8", 32'hA500_0000, 32'h7800_0000);
    sample_size = 3'd4;
    push(32'h00AB_CDEF, 32'hFF12_3456);
    pop_expect("size24", 32'hABCD_EF00, 32'h1234_5600);
    sample_size = 3'd1;
    push(32'hFFFF_FABC, 32'h0000_0123);
    pop_expect("size12", 32'hABC0_0000, 32'h1230_0000);
    sample_size = 3'd5;
    push(32'h9876_5432, 32'h0000_00FF);
    sample_size = 3'd7;
    pop_expect("size7_rdtime", 32'h5432_0000, 32'h00FF_0000);
    check("final_level", 64'(level), 64'(4'd0));
    check("final_underrun", 64'(underrun), 64'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
